// File: rtl/mem_port_arbiter.sv
// Arbiter/sequencer for the memory port shared by instruction fetch and data access.
// Data wins a tie unless it won the previous grant; aborted fetches drain without a ready.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  input  logic                if_abort,
  output logic                if_ready,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                mem_req,
  input  logic                mem_we,
  input  logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W/8-1:0] mem_be,
  output logic                mem_ready,
  output logic [DATA_W-1:0]   mem_rdata,
  output logic                stall_if,
  output logic                stall_mem,
  output logic                bus_valid,
  output logic                bus_we,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W-1:0]   bus_wdata,
  output logic [DATA_W/8-1:0] bus_be,
  input  logic                bus_ack,
  input  logic [DATA_W-1:0]   bus_rdata,
  output logic                bus_err
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  // The access is forced complete on the TIMEOUT-th waiting cycle, i.e. count TIMEOUT-1.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_D_ACC  = 2'd1,
    S_I_ACC  = 2'd2,
    S_I_DROP = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic                last_data_q, last_data_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                bus_valid_q, bus_valid_d;
  logic                bus_we_q, bus_we_d;
  logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0]   bus_wdata_q, bus_wdata_d;
  logic [BE_W-1:0]     bus_be_q, bus_be_d;
  logic                bus_err_q, bus_err_d;

  logic busy_s, timeout_s, done_s, grant_d_s, grant_i_s;
  logic if_ready_s, mem_ready_s;

  assign busy_s    = (state_q != S_IDLE);
  assign timeout_s = busy_s && !bus_ack && (cnt_q == CNT_LAST);
  assign done_s    = busy_s && (bus_ack || timeout_s);
  assign grant_d_s = mem_req && (!if_req || !last_data_q);
  assign grant_i_s = if_req && !grant_d_s;

  // State and bus payload registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      last_data_q <= 1'b0;
      cnt_q       <= {CNT_W{1'b0}};
      bus_valid_q <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= {ADDR_W{1'b0}};
      bus_wdata_q <= {DATA_W{1'b0}};
      bus_be_q    <= {BE_W{1'b0}};
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_data_q <= last_data_d;
      cnt_q       <= cnt_d;
      bus_valid_q <= bus_valid_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_be_q    <= bus_be_d;
      bus_err_q   <= bus_err_d;
    end
  end

  // Next state, grant and payload capture
  always_comb begin
    state_d     = state_q;
    last_data_d = last_data_q;
    cnt_d       = cnt_q;
    bus_valid_d = bus_valid_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_be_d    = bus_be_q;
    bus_err_d   = timeout_s;
    case (state_q)
      S_IDLE: begin
        if (grant_d_s) begin
          state_d     = S_D_ACC;
          last_data_d = 1'b1;
          cnt_d       = {CNT_W{1'b0}};
          bus_valid_d = 1'b1;
          bus_we_d    = mem_we;
          bus_addr_d  = mem_addr;
          bus_wdata_d = mem_wdata;
          bus_be_d    = mem_be;
        end else if (grant_i_s) begin
          state_d     = S_I_ACC;
          last_data_d = 1'b0;
          cnt_d       = {CNT_W{1'b0}};
          bus_valid_d = 1'b1;
          bus_we_d    = 1'b0;
          bus_addr_d  = if_addr;
          bus_wdata_d = {DATA_W{1'b0}};
          bus_be_d    = {BE_W{1'b1}};
        end else begin
          state_d = S_IDLE;
        end
      end
      S_D_ACC, S_I_DROP: begin
        if (done_s) begin
          state_d     = S_IDLE;
          cnt_d       = {CNT_W{1'b0}};
          bus_valid_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_I_ACC: begin
        if (done_s) begin
          state_d     = S_IDLE;
          cnt_d       = {CNT_W{1'b0}};
          bus_valid_d = 1'b0;
        end else if (if_abort) begin
          // The request is already on the bus and cannot be retracted, so drain it.
          state_d = S_I_DROP;
          cnt_d   = cnt_q + CNT_W'(1);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d     = S_IDLE;
        bus_valid_d = 1'b0;
      end
    endcase
  end

  // Completion strobes, read data and stall requests
  always_comb begin
    mem_ready_s = (state_q == S_D_ACC) && done_s;
    if_ready_s  = (state_q == S_I_ACC) && done_s && !if_abort;
    if (mem_ready_s && bus_ack) begin
      mem_rdata = bus_rdata;
    end else begin
      mem_rdata = {DATA_W{1'b0}};
    end
    if (if_ready_s && bus_ack) begin
      if_rdata = bus_rdata;
    end else begin
      if_rdata = {DATA_W{1'b0}};
    end
    mem_ready = mem_ready_s;
    if_ready  = if_ready_s;
    stall_if  = if_req && !if_ready_s;
    stall_mem = mem_req && !mem_ready_s;
  end

  assign bus_valid = bus_valid_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign bus_be    = bus_be_q;
  assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by randomized
// traffic, all compared against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int BW  = 4;
  localparam int TMO = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, if_abort, mem_req, mem_we, bus_ack;
  logic [AW-1:0] if_addr, mem_addr;
  logic [DW-1:0] mem_wdata, bus_rdata;
  logic [BW-1:0] mem_be;
  logic          if_ready, mem_ready, stall_if, stall_mem;
  logic          bus_valid, bus_we, bus_err;
  logic [DW-1:0] if_rdata, mem_rdata, bus_wdata;
  logic [AW-1:0] bus_addr;
  logic [BW-1:0] bus_be;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_abort(if_abort),
    .if_ready(if_ready), .if_rdata(if_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .stall_if(stall_if), .stall_mem(stall_mem),
    .bus_valid(bus_valid), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_be(bus_be),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // One outstanding bus transaction, as the rules describe it.
  typedef struct {
    bit          busy;
    bit          is_data;
    bit          dropped;
    int          age;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } txn_t;

  txn_t cur;
  bit   m_last_data;
  bit   m_err;

  logic        obs_if_ready, obs_mem_ready, obs_bus_valid, obs_bus_err;
  logic [31:0] obs_if_rdata, obs_mem_rdata, obs_bus_addr;
  logic [3:0]  obs_bus_be;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    cur.busy    = 1'b0;
    cur.is_data = 1'b0;
    cur.dropped = 1'b0;
    cur.age     = 0;
    cur.we      = 1'b0;
    cur.addr    = 32'h0;
    cur.wdata   = 32'h0;
    cur.be      = 4'h0;
    m_last_data = 1'b0;
    m_err       = 1'b0;
  endtask

  // Compare this cycle's outputs with the model, then advance the model past the edge.
  task automatic check_cycle();
    bit tmo, done, e_mr, e_ir;
    tmo  = cur.busy && !bus_ack && (cur.age == TMO - 1);
    done = cur.busy && (bus_ack || tmo);
    e_mr = done && cur.is_data;
    e_ir = done && !cur.is_data && !cur.dropped && !if_abort;

    chk1("bus_valid", bus_valid, cur.busy);
    if (cur.busy) begin
      chk("bus_addr", bus_addr, cur.addr);
      chk1("bus_we", bus_we, cur.we);
      chk("bus_be", 32'(bus_be), 32'(cur.be));
      if (cur.is_data && cur.we) chk("bus_wdata", bus_wdata, cur.wdata);
    end
    chk1("bus_err", bus_err, m_err);
    chk1("mem_ready", mem_ready, e_mr);
    chk1("if_ready", if_ready, e_ir);
    chk1("stall_mem", stall_mem, mem_req && !e_mr);
    chk1("stall_if", stall_if, if_req && !e_ir);
    if (e_mr && !cur.we) chk("mem_rdata", mem_rdata, bus_ack ? bus_rdata : 32'h0);
    if (e_ir) chk("if_rdata", if_rdata, bus_ack ? bus_rdata : 32'h0);

    obs_if_ready  = if_ready;
    obs_mem_ready = mem_ready;
    obs_if_rdata  = if_rdata;
    obs_mem_rdata = mem_rdata;
    obs_bus_valid = bus_valid;
    obs_bus_err   = bus_err;
    obs_bus_addr  = bus_addr;
    obs_bus_be    = bus_be;

    m_err = tmo;
    if (cur.busy) begin
      if (done) begin
        cur.busy = 1'b0;
      end else begin
        cur.age++;
        if (!cur.is_data && if_abort) cur.dropped = 1'b1;
      end
    end else if (mem_req && (!if_req || !m_last_data)) begin
      cur.busy    = 1'b1;
      cur.is_data = 1'b1;
      cur.dropped = 1'b0;
      cur.age     = 0;
      cur.we      = mem_we;
      cur.addr    = mem_addr;
      cur.wdata   = mem_wdata;
      cur.be      = mem_be;
      m_last_data = 1'b1;
    end else if (if_req) begin
      cur.busy    = 1'b1;
      cur.is_data = 1'b0;
      cur.dropped = 1'b0;
      cur.age     = 0;
      cur.we      = 1'b0;
      cur.addr    = if_addr;
      cur.be      = 4'hF;
      m_last_data = 1'b0;
    end
  endtask

  // Entered at posedge+1 with inputs already driven; leaves at the next posedge+1.
  task automatic step();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit if_pend, mem_pend;
    rst = 1'b0; if_req = 1'b0; if_abort = 1'b0; if_addr = 32'h0;
    mem_req = 1'b0; mem_we = 1'b0; mem_addr = 32'h0; mem_wdata = 32'h0; mem_be = 4'h0;
    bus_ack = 1'b0; bus_rdata = 32'h0;
    model_reset();
    #1 rst = 1'b1;
    #1;
    chk1("rst_bus_valid", bus_valid, 1'b0);
    chk1("rst_bus_we", bus_we, 1'b0);
    chk("rst_bus_addr", bus_addr, 32'h0);
    chk("rst_bus_wdata", bus_wdata, 32'h0);
    chk("rst_bus_be", 32'(bus_be), 32'h0);
    chk1("rst_bus_err", bus_err, 1'b0);
    chk1("rst_mem_ready", mem_ready, 1'b0);
    chk1("rst_if_ready", if_ready, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // Single load, ack on the third valid cycle
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h100; mem_be = 4'hF;
    step();
    step();
    chk1("load_stall_wait", stall_mem, 1'b1);
    step();
    bus_ack = 1'b1; bus_rdata = 32'hDEADBEEF;
    step();
    chk1("load_ready", obs_mem_ready, 1'b1);
    chk("load_rdata", obs_mem_rdata, 32'hDEADBEEF);
    bus_ack = 1'b0; mem_req = 1'b0;
    step();

    // Both requesters held, zero-wait ack: grants must alternate
    if_req = 1'b1; if_addr = 32'h400; mem_req = 1'b1; mem_addr = 32'h800; bus_ack = 1'b1;
    for (int k = 0; k < 8; k++) begin
      bus_rdata = 32'hA000_0000 + 32'(k);
      step();
      if (k % 2 == 1) chk("alt_grant", obs_bus_addr, (k % 4 == 1) ? 32'h400 : 32'h800);
    end
    if_req = 1'b0; mem_req = 1'b0; bus_ack = 1'b0;
    step();

    // Abort one cycle after fetch grant, ack two cycles later, then a fresh fetch
    if_req = 1'b1; if_addr = 32'h300;
    step();
    if_abort = 1'b1; if_req = 1'b0;
    step();
    if_abort = 1'b0;
    step();
    bus_ack = 1'b1; bus_rdata = 32'h1111_1111;
    step();
    chk1("drop_no_ready", obs_if_ready, 1'b0);
    chk1("drop_valid_held", obs_bus_valid, 1'b1);
    bus_ack = 1'b0; if_req = 1'b1; if_addr = 32'h200;
    step();
    bus_ack = 1'b1; bus_rdata = 32'h2222_2222;
    step();
    chk1("refetch_ready", obs_if_ready, 1'b1);
    chk("refetch_addr", obs_bus_addr, 32'h200);
    chk("refetch_rdata", obs_if_rdata, 32'h2222_2222);

    // Abort coinciding with ack
    bus_ack = 1'b0; if_addr = 32'h500;
    step();
    if_abort = 1'b1; bus_ack = 1'b1; bus_rdata = 32'h3333_3333;
    step();
    chk1("abort_ack_no_ready", obs_if_ready, 1'b0);
    if_abort = 1'b0; bus_ack = 1'b0; if_req = 1'b0;
    step();
    chk1("abort_ack_idle", obs_bus_valid, 1'b0);

    // Timeout with no ack
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h600; bus_rdata = 32'hFFFF_FFFF;
    step();
    step(); step(); step();
    step();
    chk1("tmo_ready", obs_mem_ready, 1'b1);
    chk("tmo_rdata", obs_mem_rdata, 32'h0);
    mem_req = 1'b0;
    step();
    chk1("tmo_err", obs_bus_err, 1'b1);
    chk1("tmo_valid_drop", obs_bus_valid, 1'b0);

    // Store, then reset two cycles into the wait
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h700; mem_wdata = 32'h1234; mem_be = 4'b0011;
    step();
    step();
    chk("store_be", 32'(obs_bus_be), 32'h3);
    step();
    rst = 1'b1;
    #1;
    chk1("rrst_bus_valid", bus_valid, 1'b0);
    chk1("rrst_bus_we", bus_we, 1'b0);
    chk("rrst_bus_addr", bus_addr, 32'h0);
    chk("rrst_bus_wdata", bus_wdata, 32'h0);
    chk("rrst_bus_be", 32'(bus_be), 32'h0);
    chk1("rrst_bus_err", bus_err, 1'b0);
    chk1("rrst_mem_ready", mem_ready, 1'b0);
    bus_ack = 1'b1;
    @(negedge clk);
    chk1("rrst_no_ready_on_ack", mem_ready, 1'b0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0; mem_req = 1'b0; mem_we = 1'b0; bus_ack = 1'b0;

    // Randomized traffic with protocol-following requesters
    if_pend = 1'b0; mem_pend = 1'b0;
    obs_if_ready = 1'b0; obs_mem_ready = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      if (mem_pend && obs_mem_ready) mem_pend = 1'b0;
      if (if_pend && obs_if_ready) if_pend = 1'b0;
      if_abort = 1'b0;
      if (if_pend) begin
        if ($urandom_range(0, 9) == 0) begin
          if_abort = 1'b1;
          if_pend  = 1'b0;
        end
      end else if ($urandom_range(0, 2) == 0) begin
        if_pend = 1'b1;
        if_addr = $urandom & 32'hFFFF_FFFC;
      end else if ($urandom_range(0, 29) == 0) begin
        if_abort = 1'b1;
      end
      if_req = if_pend;
      if (!mem_pend && $urandom_range(0, 2) == 0) begin
        mem_pend  = 1'b1;
        mem_we    = 1'($urandom_range(0, 1));
        mem_addr  = $urandom;
        mem_wdata = $urandom;
        mem_be    = 4'($urandom_range(1, 15));
      end
      mem_req   = mem_pend;
      bus_ack   = ($urandom_range(0, 9) < 4);
      bus_rdata = $urandom;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter and sequencer for the single shared memory port used by the pipeline's IF stage (instruction fetch) and MEM stage (load/store). It grants the port to one requester at a time and drives the bus handshake. It returns read data and a one-cycle ready strobe, and produces the stall requests the pipeline combines with the load-use/branch hazard stalls. Data accesses normally win; alternation prevents fetch starvation. Fetches that are in flight during a control-flow redirect are cancelled.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width (byte enables are DATA_W/8 bits)
- TIMEOUT, 255, max cycles to wait for bus_ack before forced completion with error

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- if_req  in  1  fetch request, held until if_ready
- if_addr  in  ADDR_W  fetch address, stable while if_req
- if_abort  in  1  redirect pulse, cancels any in-flight fetch
- if_ready  out  1  fetch complete this cycle
- if_rdata  out  DATA_W  fetch data, valid with if_ready
- mem_req  in  1  data request, held until mem_ready
- mem_we  in  1  1 = store, 0 = load
- mem_addr  in  ADDR_W  data address
- mem_wdata  in  DATA_W  store data
- mem_be  in  DATA_W/8  byte enables
- mem_ready  out  1  data access complete this cycle
- mem_rdata  out  DATA_W  load data, valid with mem_ready
- stall_if  out  1  if_req & ~if_ready (combinational)
- stall_mem  out  1  mem_req & ~mem_ready (combinational)
- bus_valid  out  1  bus request, registered
- bus_we, bus_addr, bus_wdata, bus_be  out  1/ADDR_W/DATA_W/DATA_W/8  registered payload
- bus_ack  in  1  one-cycle completion
- bus_rdata  in  DATA_W  valid with bus_ack
- bus_err  out  1  one-cycle pulse on timeout completion

## Operation
- **States:**
  - IDLE
  - D_ACC: data access owns the bus
  - I_ACC: fetch owns the bus
  - I_DROP: aborted fetch, draining
- **IDLE grant:**
  - Only mem_req: go to D_ACC.
  - Only if_req: go to I_ACC.
  - Both: grant data unless last_grant == data, in which case grant fetch.
  - last_grant updates on each grant.
- **On grant:** latch payload into the bus_* registers and set bus_valid=1. The payload stays stable until ack/timeout. Fetches drive bus_we=0 and bus_be all ones.
- **D_ACC:**
  - On bus_ack: mem_ready=1 and mem_rdata=bus_rdata (both combinational); clear bus_valid; go to IDLE.
  - Stores also complete on ack; mem_rdata is don't-care.
- **I_ACC:**
  - On bus_ack: if_ready=1 and if_rdata=bus_rdata; go to IDLE.
  - if_abort without ack: go to I_DROP.
  - if_abort in the same cycle as ack: suppress if_ready and go to IDLE.
- **I_DROP:** bus_valid stays high (a request cannot be retracted). On ack, go to IDLE with no if_ready.
- **if_abort in IDLE:** no effect.
- **Wait counter:** clears on grant and increments each cycle that bus_valid=1 without ack. When it reaches TIMEOUT:
  - Treat the cycle as an ack with rdata forced to 0.
  - Pulse bus_err.
  - I_DROP still suppresses if_ready.
- **Ignored inputs:** bus_ack in IDLE is ignored.

## Timing
- Reset values:
  - All registered outputs 0: bus_valid, bus_we, bus_addr, bus_wdata, bus_be, bus_err.
  - State IDLE, last_grant = fetch, counter 0.
  - if_ready and mem_ready are 0 in IDLE and during reset.
- **Minimum access:** req seen at cycle N, bus_valid at N+1, earliest ack N+1, ready at N+1. The requester's pipeline register advances at the end of N+1.
- **Re-issue:** a new request is first sampled the cycle after ready (IDLE). Back-to-back accesses therefore occupy every other bus cycle at minimum.
- **Ready rules:** ready is asserted only in a cycle where bus_ack (or timeout) is present. At most one of if_ready and mem_ready is high per cycle.
- **Stalls:** stall_if and stall_mem are purely combinational and are 0 whenever the corresponding req is 0.
- **Reset mid-access:** state returns to IDLE and bus_valid drops immediately (async). The in-flight access is lost and no ready is generated.

## Test plan
- **Single load:** mem_req, addr 0x100, ack 3 cycles after bus_valid with rdata 0xDEADBEEF -> bus_valid for 3 cycles with addr 0x100 and we=0; mem_ready for one cycle with 0xDEADBEEF; stall_mem high until then.
- **Simultaneous requests, both held:** if_req and mem_req every cycle, zero-wait ack -> grants alternate D, I, D, I. No two consecutive grants to data while a fetch is pending.
- **Abort mid-fetch:** if_abort one cycle after the fetch grant, ack two cycles later -> bus_valid held until ack, no if_ready, IDLE next. A new if_req at 0x200 is then issued normally.
- **Abort coinciding with ack** -> if_ready stays 0 and the state returns to IDLE.
- **Timeout:** TIMEOUT=4, no ack -> after 4 valid cycles, bus_err pulses, mem_ready=1 with mem_rdata=0, and bus_valid drops.
- **Store, then reset mid-access:** store with be=0011 and wdata 0x1234 -> payload stable with be=0011 on the bus. Asserting rst two cycles into the wait drives all outputs to 0 asynchronously and gives no mem_ready.
